// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: branch codes, FSM states, PC step.
package program_sequencer_pkg;

    localparam int unsigned BR_OP_W = 3;
    localparam int unsigned DEPTH_W = 3;
    localparam int unsigned PC_INC  = 2;

    typedef enum logic [BR_OP_W-1:0] {
        BR_NONE  = 3'd0,
        BR_B     = 3'd1,
        BR_BCOND = 3'd2,
        BR_CALL  = 3'd3,
        BR_RET   = 3'd4,
        BR_CALA  = 3'd5
    } br_op_e;

    typedef enum logic {
        ST_FETCH   = 1'b0,
        ST_OPERAND = 1'b1
    } seq_state_e;

endpackage

// File: rtl/program_sequencer_return_stack.sv
// Hardware return-address stack; overflow drops the oldest entry, underflow
// returns the retained bottom entry. Both conditions raise sticky flags.
module return_stack
    import program_sequencer_pkg::*;
#(
    parameter int unsigned AW          = 12,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic [AW-1:0]      push_data,
    output logic [AW-1:0]      top,
    output logic [DEPTH_W-1:0] depth,
    output logic               ovf,
    output logic               unf
);

    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AW-1:0]      entries [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic               full;
    logic               empty;

    assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    // Empty stack still presents the bottom slot so an underflowing pop has a value.
    assign top = empty ? entries[0] : entries[IDX_W'(depth_q - DEPTH_W'(1))];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                entries[IDX_W'(i)] <= '0;
            end
            depth_q <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else if (push) begin
            if (full) begin
                for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) begin
                    entries[IDX_W'(i)] <= entries[IDX_W'(i + 1)];
                end
                entries[IDX_W'(STACK_DEPTH - 1)] <= push_data;
                ovf <= 1'b1;
            end else begin
                entries[IDX_W'(depth_q)] <= push_data;
                depth_q <= depth_q + DEPTH_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                depth_q <= depth_q - DEPTH_W'(1);
            end
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter sequencer: two-word branches via an OPERAND state,
// single-cycle RET/CALA, and a hardware return stack.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int unsigned AW          = 12,
    parameter int unsigned DW          = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DW-1:0]      instr_rdata,
    input  logic [BR_OP_W-1:0] br_op,
    input  logic               cond_true,
    input  logic [AW-1:0]      acc_target,
    input  logic               stall,
    output logic [AW-1:0]      pc_addr,
    output logic [DW-1:0]      instr_out,
    output logic               instr_valid,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               stack_ovf,
    output logic               stack_unf
);

    seq_state_e    state_q, state_d;
    br_op_e        op_q, op_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] operand_target;
    logic [AW-1:0] stk_top;
    logic          stk_push;
    logic          stk_pop;

    assign pc_inc         = pc_q + AW'(PC_INC);
    assign operand_target = instr_rdata[AW-1:0];

    assign pc_addr     = pc_q;
    assign instr_out   = instr_rdata;
    assign instr_valid = (state_q == ST_FETCH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
            op_q <= BR_NONE;
        end else begin
            pc_q <= pc_d;
            op_q <= op_d;
        end
    end

    // Next PC / state; stall freezes everything including stack traffic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pc_d     = pc_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (!stall) begin
            case (state_q)
                ST_FETCH: begin
                    case (br_op)
                        BR_B, BR_BCOND, BR_CALL: begin
                            op_d    = br_op_e'(br_op);
                            pc_d    = pc_inc;
                            state_d = ST_OPERAND;
                        end
                        BR_RET: begin
                            stk_pop = 1'b1;
                            pc_d    = stk_top;
                        end
                        BR_CALA: begin
                            stk_push = 1'b1;
                            pc_d     = acc_target;
                        end
                        default: pc_d = pc_inc;
                    endcase
                end
                ST_OPERAND: begin
                    case (op_q)
                        BR_B:     pc_d = operand_target;
                        BR_BCOND: pc_d = cond_true ? operand_target : pc_inc;
                        BR_CALL: begin
                            stk_push = 1'b1;
                            pc_d     = operand_target;
                        end
                        default:  pc_d = pc_inc;
                    endcase
                    op_d    = BR_NONE;
                    state_d = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    return_stack #(
        .AW          (AW),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .depth     (stack_depth),
        .ovf       (stack_ovf),
        .unf       (stack_unf)
    );

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter AW, default 12, program address width.
REQ-002 SHALL have parameter DW, default 16, instruction word width.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, hardware return-stack entries.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port instr_rdata, input, DW bits, combinational instruction memory read data for pc_addr.
REQ-007 SHALL have port br_op, input, 3 bits, control LUT branch code: 0 NONE, 1 B, 2 BCOND, 3 CALL, 4 RET, 5 CALA; 6 and 7 are treated as NONE.
REQ-008 SHALL have port cond_true, input, 1 bit, condition result from the accumulator flags, sampled only in OPERAND.
REQ-009 SHALL have port acc_target, input, AW bits, accumulator low bits, used as the CALA target.
REQ-010 SHALL have port stall, input, 1 bit, freezes all sequencer state.
REQ-011 SHALL have port pc_addr, output, AW bits, instruction memory address.
REQ-012 SHALL have port instr_out, output, DW bits, instruction word sent to the decoder and LUT.
REQ-013 SHALL have port instr_valid, output, 1 bit, high when instr_out is an executable opcode.
REQ-014 SHALL have port stack_depth, output, 3 bits, number of valid stack entries.
REQ-015 SHALL have port stack_ovf, output, 1 bit, sticky flag, set on a push while the stack is full.
REQ-016 SHALL have port stack_unf, output, 1 bit, sticky flag, set on a pop while the stack is empty.

Function
REQ-017 SHALL implement an FSM with states FETCH and OPERAND; pc_addr SHALL equal the PC register, and instr_out SHALL equal instr_rdata.
REQ-018 In FETCH, instr_valid SHALL be 1. In OPERAND, instr_valid SHALL be 0, because the second word is an address, not an opcode.
REQ-019 In FETCH with br_op NONE, PC SHALL become PC+2, modulo 2^AW, wrapping from 0xFFE to 0x000.
REQ-020 In FETCH with br_op B, BCOND or CALL, PC SHALL become PC+2 and the state SHALL become OPERAND; the decoded op SHALL be latched.
REQ-021 In OPERAND, target SHALL be instr_rdata[AW-1:0]. B SHALL take target unconditionally; BCOND SHALL take target if cond_true=1, else PC+2; CALL SHALL push PC+2 and take target. The state SHALL then return to FETCH.
REQ-022 In FETCH with br_op RET, PC SHALL become the popped top-of-stack, in a single cycle.
REQ-023 In FETCH with br_op CALA, the sequencer SHALL push PC+2 and PC SHALL become acc_target, in a single cycle.
REQ-024 br_op SHALL be ignored in OPERAND.
REQ-025 Stack push when stack_depth=STACK_DEPTH SHALL discard the bottom entry, keep depth at STACK_DEPTH, and set stack_ovf.
REQ-026 Stack pop when stack_depth=0 SHALL return the retained bottom entry (0 after reset), keep depth at 0, and set stack_unf.
REQ-027 While stall=1, PC, state, stack, depth and flags SHALL hold; br_op SHALL be ignored; outputs SHALL remain stable.
REQ-028 Latency: a taken two-word branch SHALL cost 2 cycles, RET and CALA 1 cycle, with no extra bubble.

Reset
REQ-029 While reset_n=0, the block SHALL asynchronously set PC=0, state=FETCH, stack_depth=0, all stack entries=0, stack_ovf=0 and stack_unf=0.
REQ-030 Reset SHALL take effect mid-OPERAND; the pending branch SHALL be abandoned.
REQ-031 After reset release, the first fetch SHALL be from address 0x000 with instr_valid=1.

Structure
REQ-032 A shared package SHALL hold the br_op encodings, the FSM state enum, and the PC increment constant (2).
REQ-033 The return stack SHALL be one sub-module, return_stack (push, pop, top, depth, ovf, unf), parameterised by AW and STACK_DEPTH.

Verification
REQ-034 Reset then 3 NONE cycles -> pc_addr 0x000, 0x002, 0x004, 0x006; instr_valid=1 throughout.
REQ-035 At PC=0x010, B with operand word 0x0123 -> valid 1,0, then pc_addr=0x123 on the third cycle.
REQ-036 At PC=0x020, BCOND with operand 0x080: cond_true=0 -> next pc_addr 0x024; cond_true=1 -> next pc_addr 0x080.
REQ-037 At PC=0x040, CALL with operand 0x200, then RET at 0x200 -> depth goes 1 then 0; pc_addr returns to 0x044.
REQ-038 5 CALAs (targets 0x100..0x500) then 5 RETs -> stack_ovf=1 after the 5th push; the 4 returns pop the newest entries first; the 5th RET returns the bottom entry and sets stack_unf=1.
REQ-039 Assert stall mid-OPERAND for 3 cycles, and assert reset_n=0 mid-OPERAND -> stall: no state change, branch completes after release; reset: pc_addr=0x000, depth=0, state FETCH immediately.
